mem_port_arbiter: RTL and testbench

Arbitrates one synchronous 16-bit memory port between the fetch unit and the load/store data path. Fetch requests read an aligned word pair and return a packed 32-bit opcode that feeds `fetch_unit.fetch_opc`. Data requests perform a single 16-bit read or write. A round-robin FSM sequences the shared port, drives `hold` back to the fetch unit, and discards in-flight fetches on a PC redirect.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory port between
// instruction fetch (word pairs) and load/store (single words).
module mem_port_arbiter #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          fe_req,
  input  logic [AW-1:0] fe_addr,
  input  logic          fe_flush,
  output logic [31:0]   fe_opc,
  output logic          fe_valid,
  output logic          hold,
  input  logic          dt_req,
  input  logic          dt_we,
  input  logic [AW-1:0] dt_addr,
  input  logic [15:0]   dt_wdata,
  output logic [15:0]   dt_rdata,
  output logic          dt_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    FE0,
    FE1,
    FE2,
    DT0,
    DT1
  } state_t;

  state_t        state;
  logic          last_dt;
  logic          drop;
  logic          d_we;
  logic [AW-2:0] pair;
  logic [15:0]   opc_hi;
  logic          grant_fe;
  logic          grant_dt;

  // On a tie the side not served last wins.
  always_comb begin
    grant_fe = fe_req & (~dt_req | last_dt);
    grant_dt = dt_req & (~fe_req | ~last_dt);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state     <= IDLE;
      last_dt   <= 1'b1;
      drop      <= 1'b0;
      d_we      <= 1'b0;
      pair      <= '0;
      opc_hi    <= '0;
      fe_opc    <= '0;
      fe_valid  <= 1'b0;
      hold      <= 1'b1;
      dt_rdata  <= '0;
      dt_ack    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      fe_valid <= 1'b0;
      dt_ack   <= 1'b0;
      hold     <= 1'b1;
      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          unique case (1'b1)
            grant_fe: begin
              state    <= FE0;
              pair     <= fe_addr[AW-1:1];
              drop     <= fe_flush;
              mem_addr <= {fe_addr[AW-1:1], 1'b0};
            end
            grant_dt: begin
              state     <= DT0;
              d_we      <= dt_we;
              mem_addr  <= dt_addr;
              mem_we    <= dt_we;
              mem_wdata <= dt_wdata;
            end
            default: ;
          endcase
        end
        FE0: begin
          state    <= FE1;
          drop     <= drop | fe_flush;
          mem_addr <= {pair, 1'b1};
        end
        FE1: begin
          state    <= FE2;
          drop     <= drop | fe_flush;
          opc_hi   <= mem_rdata;
          mem_addr <= '0;
        end
        FE2: begin
          state   <= IDLE;
          drop    <= 1'b0;
          last_dt <= 1'b0;
          // A flush in this very cycle still kills the pulse.
          if (!(drop | fe_flush)) begin
            fe_opc   <= {opc_hi, mem_rdata};
            fe_valid <= 1'b1;
            hold     <= 1'b0;
          end
        end
        DT0: begin
          state     <= DT1;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
        end
        DT1: begin
          state   <= IDLE;
          last_dt <= 1'b1;
          dt_ack  <= 1'b1;
          if (!d_we) dt_rdata <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then
// randomized contention against a reference memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        fe_req, fe_flush;
  logic [14:0] fe_addr;
  logic [31:0] fe_opc;
  logic        fe_valid, hold;
  logic        dt_req, dt_we;
  logic [14:0] dt_addr;
  logic [15:0] dt_wdata, dt_rdata;
  logic        dt_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy;

  mem_port_arbiter #(.AW(15)) dut (
    .clk(clk), .a_rst(a_rst),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_flush(fe_flush),
    .fe_opc(fe_opc), .fe_valid(fe_valid), .hold(hold),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr),
    .dt_wdata(dt_wdata), .dt_rdata(dt_rdata), .dt_ack(dt_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM attached to the port, and the reference copy.
  logic [15:0] ram [0:32767];
  logic [15:0] ref_mem [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i] = i[15:0];
      ref_mem[i] = i[15:0];
    end
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [31:0] opc;
    int          at;
  } fe_exp_t;
  typedef struct {
    logic        we;
    logic [15:0] rdata;
    int          at;
  } dt_exp_t;

  fe_exp_t fe_q[$];
  dt_exp_t dt_q[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] last_opc = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pair_of(input logic [14:0] a);
    logic [14:0] ev;
    ev = {a[14:1], 1'b0};
    return {ref_mem[ev], ref_mem[ev | 15'd1]};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response.
  fe_exp_t fe_e;
  dt_exp_t dt_e;
  always @(negedge clk) begin
    if (a_rst) begin
      chk("hold", {31'd0, hold}, {31'd0, ~fe_valid});
      if (fe_valid) begin
        if (fe_q.size() == 0) begin
          chk("fe_valid_unexpected", 32'd1, 32'd0);
        end else begin
          fe_e = fe_q.pop_front();
          chk("fe_opc", fe_opc, fe_e.opc);
          if (fe_e.at >= 0) chk("fe_cycle", cyc, fe_e.at);
          last_opc = fe_e.opc;
        end
      end
      if (dt_ack) begin
        if (dt_q.size() == 0) begin
          chk("dt_ack_unexpected", 32'd1, 32'd0);
        end else begin
          dt_e = dt_q.pop_front();
          if (!dt_e.we) chk("dt_rdata", {16'd0, dt_rdata},
                            {16'd0, dt_e.rdata});
          if (dt_e.at >= 0) chk("dt_cycle", cyc, dt_e.at);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_opc"}, fe_opc, 32'd0);
    chk({nm, "_valid"}, {31'd0, fe_valid}, 32'd0);
    chk({nm, "_hold"}, {31'd0, hold}, 32'd1);
    chk({nm, "_rdata"}, {16'd0, dt_rdata}, 32'd0);
    chk({nm, "_ack"}, {31'd0, dt_ack}, 32'd0);
    chk({nm, "_maddr"}, {17'd0, mem_addr}, 32'd0);
    chk({nm, "_mwe"}, {31'd0, mem_we}, 32'd0);
    chk({nm, "_mwdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Called at posedge+1 with the arbiter idle.
  task automatic do_fetch(input logic [14:0] a);
    fe_exp_t e;
    logic [14:0] ev;
    bit got;
    ev = {a[14:1], 1'b0};
    e.opc = pair_of(a);
    e.at = cyc + 4;
    fe_q.push_back(e);
    fe_addr = a;
    fe_req = 1'b1;
    @(posedge clk); #1;
    chk("fe_even_addr", {17'd0, mem_addr}, {17'd0, ev});
    @(posedge clk); #1;
    chk("fe_odd_addr", {17'd0, mem_addr}, {17'd0, ev | 15'd1});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = fe_valid;
    end
    if (!got) chk("fe_timeout", 32'd1, 32'd0);
    fe_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_data(input logic we, input logic [14:0] a,
                         input logic [15:0] wd);
    dt_exp_t e;
    e.we = we;
    e.rdata = ref_mem[a];
    e.at = cyc + 3;
    if (we) ref_mem[a] = wd;
    dt_q.push_back(e);
    dt_we = we;
    dt_addr = a;
    dt_wdata = wd;
    dt_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("mem_we", {31'd0, mem_we}, {31'd0, we && k == 1});
    end
    dt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    fe_exp_t fe;
    dt_exp_t de;
    int c;
    a_rst = 1'b0;
    fe_req = 0; fe_flush = 0; fe_addr = '0;
    dt_req = 0; dt_we = 0; dt_addr = '0; dt_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk) a_rst = 1'b1;
    @(posedge clk); #1;

    // Both requesters held: fetch, data, fetch.
    c = cyc;
    fe.opc = pair_of(15'h0006);
    fe.at = c + 4;  fe_q.push_back(fe);
    de.we = 0; de.rdata = ref_mem[2]; de.at = c + 7;
    dt_q.push_back(de);
    fe.at = c + 11; fe_q.push_back(fe);
    fe_addr = 15'h0006; fe_req = 1;
    dt_addr = 15'h0002; dt_we = 0; dt_req = 1;
    repeat (7) @(posedge clk);
    #1 dt_req = 0;
    repeat (4) @(posedge clk);
    #1 fe_req = 0;
    repeat (4) @(posedge clk);
    #1;

    do_fetch(15'h0005);
    chk("opc_0005", last_opc, 32'h0004_0005);
    do_data(1'b1, 15'h0010, 16'hBEEF);
    do_data(1'b0, 15'h0010, 16'h0000);

    // Flush landing at grant, FE0..FE2 drops; in the valid cycle not.
    for (int k = 0; k <= 4; k++) begin
      c = cyc;
      if (k == 4) begin
        fe.opc = pair_of(15'h0040);
        fe.at = c + 4;
        fe_q.push_back(fe);
      end
      fe_addr = 15'h0040;
      fe_req = 1;
      fe_flush = (k == 0);
      for (int j = 1; j <= 5; j++) begin
        @(posedge clk); #1;
        fe_flush = (j == k);
        if (j == 1) fe_req = 0;
      end
      fe_flush = 0;
      chk("opc_after_flush", fe_opc, last_opc);
      repeat (2) @(posedge clk);
      #1;
    end
    fe_flush = 1;
    @(posedge clk); #1;
    fe_flush = 0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    do_fetch(15'h0020);
    chk("opc_0020", last_opc, 32'h0020_0021);

    // Reset during DT0 of a write: the write must never land.
    dt_we = 1; dt_addr = 15'h0030; dt_wdata = 16'h1234; dt_req = 1;
    @(posedge clk); #1;
    chk("dt0_we", {31'd0, mem_we}, 32'd1);
    #2 a_rst = 1'b0;
    #1 chk_reset_vals("midrst");
    dt_req = 0;
    @(negedge clk) a_rst = 1'b1;
    @(posedge clk); #1;
    do_data(1'b0, 15'h0030, 16'h0000);

    do_fetch(15'h7FFF);
    chk("opc_7fff", last_opc, 32'h7FFE_7FFF);

    fork
      begin
        bit got;
        fe_exp_t e;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          fe_addr = 15'h0200 + 15'($urandom_range(0, 32255));
          e.opc = pair_of(fe_addr);
          e.at = -1;
          fe_q.push_back(e);
          fe_req = 1;
          got = 0;
          for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk); #1;
            got = fe_valid;
          end
          if (!got) chk("rnd_fe_timeout", 32'd1, 32'd0);
          fe_req = 0;
        end
      end
      begin
        bit got;
        dt_exp_t e;
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          dt_we = $urandom_range(0, 1) == 1;
          dt_addr = 15'h0100 | 15'($urandom_range(0, 255));
          dt_wdata = 16'($urandom);
          e.we = dt_we;
          e.rdata = ref_mem[dt_addr];
          e.at = -1;
          if (dt_we) ref_mem[dt_addr] = dt_wdata;
          dt_q.push_back(e);
          dt_req = 1;
          got = 0;
          for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk); #1;
            got = dt_ack;
          end
          if (!got) chk("rnd_dt_timeout", 32'd1, 32'd0);
          dt_req = 0;
        end
      end
    join

    repeat (10) @(posedge clk);
    #1;
    chk("fe_pending", fe_q.size(), 32'd0);
    chk("dt_pending", dt_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
